// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: internal instruction memory + PC stepper that feeds decode.
// Latency: start at edge N -> first instr_valid after edge N+1, then 1 instr/cycle.
// Backpressure: instr_ready low holds instr/instr_pc/instr_valid and freezes pc.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   load_en/addr/data     program-load write port (LOAD state only)
//   start                 LOAD->RUN, HALT->RUN (restart from RESET_PC)
//   instr_valid/ready     output handshake
//   instr, instr_pc       registered instruction word and its byte address
//   opcode..rs2           pure slices of instr
//   halted                high while in HALT
// Optional feature macro: BRANCH_REDIRECT_EN adds redirect_valid/redirect_pc.
module instr_fetch_unit #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_en,
    input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
    input  logic [31:0]                   load_data,
    input  logic                          start,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic [31:0]                   instr,
    output logic [6:0]                    opcode,
    output logic [2:0]                    funct3,
    output logic [6:0]                    funct7,
    output logic [4:0]                    rd,
    output logic [4:0]                    rs1,
    output logic [4:0]                    rs2,
    output logic [31:0]                   instr_pc,
`ifdef BRANCH_REDIRECT_EN
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
`endif
    output logic                          halted
);

    localparam int AW = $clog2(IMEM_DEPTH);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   pc;
    logic [31:0]   mem [IMEM_DEPTH];

    logic [AW-1:0] idx;
    logic [31:0]   fetch_word;
    logic          fetch_zero;
    logic          is_last;
    logic          out_free;
    logic          redir;
    logic [31:0]   redir_pc;
    logic          fetch_go;

    // Combinational memory read on the current pc.
    assign idx        = pc[2 +: AW];
    assign fetch_word = mem[idx];
    assign fetch_zero = (fetch_word == 32'h0000_0000);
    assign is_last    = (idx == AW'(IMEM_DEPTH - 1));
    assign out_free   = !instr_valid || instr_ready;

`ifdef BRANCH_REDIRECT_EN
    assign redir    = (state == S_RUN) && redirect_valid;
    assign redir_pc = redirect_pc & ~32'h0000_0003;
`else
    assign redir    = 1'b0;
    assign redir_pc = 32'h0000_0000;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: if (start) state_nxt = S_RUN;
            S_RUN: begin
                // A redirect suppresses the halt check for that cycle.
                if (!redir && out_free && (fetch_zero || is_last)) begin
                    state_nxt = S_HALT;
                end
            end
            S_HALT: if (start) state_nxt = S_RUN;
            default: state_nxt = S_LOAD;
        endcase
    end

    // Output / control decode
    always_comb begin
        halted   = (state == S_HALT);
        fetch_go = (state == S_RUN) && out_free && !redir;
    end

    // Program memory: written only while loading, never cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && (state == S_LOAD) && load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    // PC and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= 32'h0000_0000;
            instr_pc    <= 32'h0000_0000;
        end else begin
            case (state)
                S_LOAD: begin
                    if (start) pc <= RESET_PC;
                end
                S_RUN: begin
                    if (redir) begin
                        pc          <= redir_pc;
                        instr_valid <= 1'b0;
                    end else if (fetch_go) begin
                        if (fetch_zero) begin
                            // Terminator word is consumed, never presented.
                            instr_valid <= 1'b0;
                        end else begin
                            instr       <= fetch_word;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            // Last word: pc stays put so it never wraps to 0.
                            if (!is_last) pc <= pc + 32'd4;
                        end
                    end
                end
                S_HALT: begin
                    if (start) begin
                        pc          <= RESET_PC;
                        instr_valid <= 1'b0;
                        instr       <= 32'h0000_0000;
                        instr_pc    <= 32'h0000_0000;
                    end else if (instr_valid && instr_ready) begin
                        // Drain the final presented word, then go idle.
                        instr_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: program load, run, stall, halt, reset, restart.
// Expected (instr, instr_pc) pairs are queued when a run is launched and
// compared on every accepted transfer.
module tb_instr_fetch_unit;

    localparam logic [31:0] W_ADD = 32'h0020_8033;
    localparam logic [31:0] W_SUB = 32'h4020_8033;
    localparam logic [31:0] W_XOR = 32'h0020_C033;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    logic        start;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] instr_pc;
    logic        halted;
`ifdef BRANCH_REDIRECT_EN
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`endif

    int checks   = 0;
    int failures = 0;
    int xfers    = 0;
    int x0;

    logic [31:0] exp_instr_q [$];
    logic [31:0] exp_pc_q    [$];

    instr_fetch_unit #(.IMEM_DEPTH(64), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .instr_pc    (instr_pc),
`ifdef BRANCH_REDIRECT_EN
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`endif
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_instr_q.delete();
        exp_pc_q.delete();
    endtask

    task automatic load_word(input int a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = 6'(a);
        load_data = d;
        step();
        load_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic expect_xfer(input logic [31:0] w, input logic [31:0] p);
        exp_instr_q.push_back(w);
        exp_pc_q.push_back(p);
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            step();
            n++;
        end
        chk("halt_timeout", 32'(halted), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!instr_valid && n < budget) begin
            step();
            n++;
        end
        chk("valid_timeout", 32'(instr_valid), 32'd1);
    endtask

    // Scoreboard: a transfer occurs at the next rising edge when valid && ready.
    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready) begin
            xfers++;
            if (exp_instr_q.size() == 0) begin
                chk("unexpected_xfer", instr_pc, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] ew;
                logic [31:0] ep;
                ew = exp_instr_q.pop_front();
                ep = exp_pc_q.pop_front();
                chk("xfer_instr", instr, ew);
                chk("xfer_pc", instr_pc, ep);
                chk("xfer_fields", {funct7, rs2, rs1, funct3, rd, opcode}, ew);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        load_en     = 1'b0;
        load_addr   = '0;
        load_data   = '0;
        start       = 1'b0;
        instr_ready = 1'b0;
`ifdef BRANCH_REDIRECT_EN
        redirect_valid = 1'b0;
        redirect_pc    = '0;
`endif
        step(2);
        reset = 1'b0;

        // Reset state
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);

        // add, sub, terminator; terminator written in the same cycle as start
        load_word(0, W_ADD);
        load_word(1, W_SUB);
        expect_xfer(W_ADD, 32'h0);
        expect_xfer(W_SUB, 32'h4);
        x0          = xfers;
        instr_ready = 1'b1;
        load_en     = 1'b1;
        load_addr   = 6'd2;
        load_data   = 32'h0;
        start       = 1'b1;
        step();
        load_en = 1'b0;
        start   = 1'b0;
        wait_halt(20);
        step(3);
        chk("t1_valid_after_halt", 32'(instr_valid), 32'd0);
        chk("t1_halted", 32'(halted), 32'd1);
        chk("t1_xfers", 32'(xfers - x0), 32'd2);
        chk("t1_queue_empty", 32'(exp_instr_q.size()), 32'd0);

        // Stall: memory kept across reset, ready low for 5 cycles
        do_reset();
        instr_ready = 1'b0;
        expect_xfer(W_ADD, 32'h0);
        expect_xfer(W_SUB, 32'h4);
        x0 = xfers;
        pulse_start();
        chk("t2_lat_n", 32'(instr_valid), 32'd0);
        step();
        chk("t2_lat_n1", 32'(instr_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_instr", instr, W_ADD);
            chk("t2_hold_pc", instr_pc, 32'h0);
            chk("t2_hold_valid", 32'(instr_valid), 32'd1);
            step();
        end
        instr_ready = 1'b1;
        wait_halt(20);
        step(2);
        chk("t2_xfers", 32'(xfers - x0), 32'd2);
        chk("t2_queue_empty", 32'(exp_instr_q.size()), 32'd0);

        // Full memory: last index presented, then halt without wrap
        do_reset();
        instr_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            load_word(i, W_XOR);
            expect_xfer(W_XOR, 32'(i * 4));
        end
        x0          = xfers;
        instr_ready = 1'b1;
        pulse_start();
        wait_halt(200);
        step(8);
        chk("t3_xfers", 32'(xfers - x0), 32'd64);
        chk("t3_queue_empty", 32'(exp_instr_q.size()), 32'd0);
        chk("t3_valid_after_halt", 32'(instr_valid), 32'd0);
        chk("t3_last_pc", instr_pc, 32'h0000_00FC);
        chk("t3_halted", 32'(halted), 32'd1);

        // Reset mid-transfer with valid=1, ready=0
        do_reset();
        load_word(0, W_ADD);
        load_word(1, W_SUB);
        load_word(2, 32'h0);
        instr_ready = 1'b0;
        pulse_start();
        wait_valid(10);
        reset = 1'b1;
        step();
        chk("t4_valid_after_rst", 32'(instr_valid), 32'd0);
        chk("t4_halted_after_rst", 32'(halted), 32'd0);
        reset = 1'b0;
        step(3);
        chk("t4_no_fetch_in_load", 32'(instr_valid), 32'd0);
        expect_xfer(W_ADD, 32'h0);
        expect_xfer(W_SUB, 32'h4);
        x0          = xfers;
        instr_ready = 1'b1;
        pulse_start();
        wait_halt(20);
        step(2);
        chk("t4_restart_xfers", 32'(xfers - x0), 32'd2);

        // Restart from HALT, then load_en in RUN must be ignored
        instr_ready = 1'b0;
        expect_xfer(W_ADD, 32'h0);
        expect_xfer(W_SUB, 32'h4);
        x0 = xfers;
        pulse_start();
        chk("t5_restart_clr_valid", 32'(instr_valid), 32'd0);
        chk("t5_restart_clr_instr", instr, 32'd0);
        chk("t5_restart_halted", 32'(halted), 32'd0);
        wait_valid(10);
        load_word(1, 32'hFFFF_FFFF);
        instr_ready = 1'b1;
        wait_halt(20);
        step(2);
        chk("t5_xfers", 32'(xfers - x0), 32'd2);
        chk("t5_queue_empty", 32'(exp_instr_q.size()), 32'd0);

`ifdef BRANCH_REDIRECT_EN
        // Redirect while instr_pc=4 is pending
        do_reset();
        for (int i = 0; i < 8; i++) load_word(i, 32'h33 | 32'(i << 7));
        load_word(8, 32'h0);
        instr_ready = 1'b0;
        expect_xfer(32'h33, 32'h0);
        pulse_start();
        wait_valid(10);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("t6_pending_pc", instr_pc, 32'h4);
        chk("t6_pending_valid", 32'(instr_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h13;
        step();
        redirect_valid = 1'b0;
        chk("t6_flush_valid", 32'(instr_valid), 32'd0);
        for (int i = 4; i < 8; i++) expect_xfer(32'h33 | 32'(i << 7), 32'(i * 4));
        instr_ready = 1'b1;
        wait_halt(20);
        step(2);
        chk("t6_queue_empty", 32'(exp_instr_q.size()), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
